// File: rtl/aes_regbank_pkg.sv
// Shared definitions for the Avalon AES register bank: FSM state encoding and register-map offsets.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package aes_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Register map, in words: key | encrypted msg | decrypted msg | scratch | START | DONE
  function automatic int unsigned key_base(input int unsigned words);
    key_base = 0 * words;
  endfunction

  function automatic int unsigned enc_base(input int unsigned words);
    enc_base = words;
  endfunction

  function automatic int unsigned dec_base(input int unsigned words);
    dec_base = 2 * words;
  endfunction

  function automatic int unsigned scratch_base(input int unsigned words);
    scratch_base = 3 * words;
  endfunction

  function automatic int unsigned start_addr(input int unsigned num_regs);
    start_addr = num_regs - 2;
  endfunction

  function automatic int unsigned done_addr(input int unsigned num_regs);
    done_addr = num_regs - 1;
  endfunction

endpackage

// File: rtl/byte_merge.sv
// Per-byte select between the current register word and incoming bus data.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
// Ports: old_word (current contents), new_word (bus data), byte_en (1 = take new byte),
//        merged_word (result to be written back).
module byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   merged_word
);

  for (genvar b = 0; b < DATA_W / 8; b++) begin : g_byte
    assign merged_word[8*b +: 8] = byte_en[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
  end

endmodule

// File: rtl/avalon_aes_regbank.sv
// Avalon-MM slave register bank feeding an AES core: key/message registers, START/DONE handshake.
// Latency: writes land on the same edge; reads return one cycle after the request.
// Backpressure: none; the slave accepts every access and never stalls the bus.
// Ports: CLK/RESET (sync, active-high); AVL_* Avalon-MM slave; EXPORT_DATA debug view of key;
//        AES_KEY/AES_MSG_ENC to the core, AES_MSG_DEC/AES_DONE from it, AES_START run request.
module avalon_aes_regbank
  import aes_regbank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int BLOCK_W  = 128,
  parameter int NUM_REGS = 16
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        AVL_READ,
  input  logic                        AVL_WRITE,
  input  logic                        AVL_CS,
  input  logic [DATA_W/8-1:0]         AVL_BYTE_EN,
  input  logic [$clog2(NUM_REGS)-1:0] AVL_ADDR,
  input  logic [DATA_W-1:0]           AVL_WRITEDATA,
  output logic [DATA_W-1:0]           AVL_READDATA,
  output logic [DATA_W-1:0]           EXPORT_DATA,
  output logic [BLOCK_W-1:0]          AES_KEY,
  output logic [BLOCK_W-1:0]          AES_MSG_ENC,
  input  logic [BLOCK_W-1:0]          AES_MSG_DEC,
  input  logic                        AES_DONE,
  output logic                        AES_START
);

  localparam int WORDS    = BLOCK_W / DATA_W;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int KEY_BASE = int'(key_base(WORDS));
  localparam int ENC_BASE = int'(enc_base(WORDS));
  localparam int DEC_BASE = int'(dec_base(WORDS));

  localparam logic [ADDR_W-1:0] DEC_A   = ADDR_W'(dec_base(WORDS));
  localparam logic [ADDR_W-1:0] SCR_A   = ADDR_W'(scratch_base(WORDS));
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(start_addr(NUM_REGS));
  localparam logic [ADDR_W-1:0] DONE_A  = ADDR_W'(done_addr(NUM_REGS));

  logic [DATA_W-1:0] regs [NUM_REGS];
  state_t            state;

  logic              wr_en;
  logic              rd_en;
  logic              addr_core_in;   // key or encrypted-message word
  logic              addr_read_only; // decrypted-message words and DONE
  logic              reg_wr;
  logic              start_wr;
  logic              start_bit;
  logic [DATA_W-1:0] merged_word;

  byte_merge #(.DATA_W(DATA_W)) u_byte_merge (
    .old_word    (regs[AVL_ADDR]),
    .new_word    (AVL_WRITEDATA),
    .byte_en     (AVL_BYTE_EN),
    .merged_word (merged_word)
  );

  always_comb begin
    wr_en          = AVL_CS & AVL_WRITE;
    rd_en          = AVL_CS & AVL_READ;
    addr_core_in   = (AVL_ADDR < DEC_A);
    addr_read_only = ((AVL_ADDR >= DEC_A) && (AVL_ADDR < SCR_A)) || (AVL_ADDR == DONE_A);
    // The core is consuming key/message while running, so freeze them.
    reg_wr         = wr_en && !addr_read_only && !(addr_core_in && (state == ST_RUN));
    // Only byte 0 carries the run bit; a write without it does not touch the FSM.
    start_wr       = wr_en && (AVL_ADDR == START_A) && AVL_BYTE_EN[0];
    start_bit      = AVL_WRITEDATA[0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[ADDR_W'(i)] <= '0;
      end
      AVL_READDATA <= '0;
      state        <= ST_IDLE;
      AES_START    <= 1'b0;
    end else begin
      // Nonblocking read of the array gives the pre-write value on a same-cycle write.
      if (rd_en) begin
        AVL_READDATA <= regs[AVL_ADDR];
      end
      if (reg_wr) begin
        regs[AVL_ADDR] <= merged_word;
      end

      // FSM writes only the decrypted and DONE words, which the bus can never write,
      // so the two assignments above and below never collide.
      unique case (state)
        ST_IDLE: begin
          if (start_wr && start_bit) begin
            state          <= ST_RUN;
            AES_START      <= 1'b1;
            regs[DONE_A]   <= '0;
          end
        end
        ST_RUN: begin
          if (start_wr && !start_bit) begin
            // Abort beats a coincident completion: nothing is captured.
            state     <= ST_IDLE;
            AES_START <= 1'b0;
          end else if (AES_DONE) begin
            state     <= ST_DONE;
            AES_START <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
              regs[ADDR_W'(DEC_BASE + i)] <= AES_MSG_DEC[BLOCK_W-1-i*DATA_W -: DATA_W];
            end
            regs[DONE_A] <= DATA_W'(1);
          end
        end
        ST_DONE: begin
          if (start_wr) begin
            state        <= start_bit ? ST_RUN : ST_IDLE;
            AES_START    <= start_bit;
            regs[DONE_A] <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          AES_START <= 1'b0;
        end
      endcase
    end
  end

  // Word 0 sits in the most significant slot of each block.
  for (genvar g = 0; g < WORDS; g++) begin : g_block
    assign AES_KEY[BLOCK_W-1-g*DATA_W -: DATA_W]     = regs[ADDR_W'(KEY_BASE + g)];
    assign AES_MSG_ENC[BLOCK_W-1-g*DATA_W -: DATA_W] = regs[ADDR_W'(ENC_BASE + g)];
  end

  assign EXPORT_DATA = {regs[ADDR_W'(KEY_BASE)][DATA_W-1:DATA_W/2],
                        regs[ADDR_W'(KEY_BASE + WORDS - 1)][DATA_W/2-1:0]};

endmodule

// File: tb/tb_avalon_aes_regbank.sv
module tb_avalon_aes_regbank;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         AVL_READ = 1'b0;
  logic         AVL_WRITE = 1'b0;
  logic         AVL_CS = 1'b0;
  logic [3:0]   AVL_BYTE_EN = 4'h0;
  logic [3:0]   AVL_ADDR = 4'h0;
  logic [31:0]  AVL_WRITEDATA = 32'h0;
  logic [31:0]  AVL_READDATA;
  logic [31:0]  EXPORT_DATA;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_ENC;
  logic [127:0] AES_MSG_DEC = 128'h0;
  logic         AES_DONE = 1'b0;
  logic         AES_START;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q [$];

  localparam logic [127:0] KEY  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] ENC  = 128'h10203040_50607080_90A0B0C0_D0E0F000;
  localparam logic [127:0] DEC1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] DEC2 = 128'h5A5AC3C3_5A5AC3C3_5A5AC3C3_5A5AC3C3;

  avalon_aes_regbank dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_CS        (AVL_CS),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .EXPORT_DATA   (EXPORT_DATA),
    .AES_KEY       (AES_KEY),
    .AES_MSG_ENC   (AES_MSG_ENC),
    .AES_MSG_DEC   (AES_MSG_DEC),
    .AES_DONE      (AES_DONE),
    .AES_START     (AES_START)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every read accepted on an edge is compared just after that edge.
  always @(posedge CLK) begin
    if (AVL_CS && AVL_READ && !RESET) begin
      #1;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rdata: observed %h with empty scoreboard expected no read", AVL_READDATA);
      end else begin
        check_val("rdata", AVL_READDATA, sb_q.pop_front());
      end
    end
  end

  task automatic bus_idle();
    AVL_CS    = 1'b0;
    AVL_READ  = 1'b0;
    AVL_WRITE = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0;
    AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0;
    AVL_ADDR = a;
    sb_q.push_back(exp);
    @(negedge CLK);
    bus_idle();
  endtask

  // Simultaneous read and write of the same word; the read must see the old value.
  task automatic rw(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                    input logic [31:0] exp_old);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b1;
    AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    sb_q.push_back(exp_old);
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic pulse_done(input logic [127:0] dec);
    @(negedge CLK);
    AES_DONE = 1'b1; AES_MSG_DEC = dec;
    @(negedge CLK);
    AES_DONE = 1'b0;
  endtask

  task automatic rd_block(input logic [3:0] base, input logic [127:0] blk);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = blk[127 - 32*i -: 32];
      rd(base + 4'(i), w);
    end
  endtask

  initial begin
    logic [31:0] key_w;
    logic [31:0] enc_w;

    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check_val("rst_start", {127'b0, AES_START}, 128'h0);
    check_val("rst_export", {96'b0, EXPORT_DATA}, 128'h0);
    check_val("rst_key", AES_KEY, 128'h0);
    check_val("rst_rdata", {96'b0, AVL_READDATA}, 128'h0);

    // Read-only words ignore writes.
    wr(4'd8, 32'hFFFFFFFF, 4'hF);
    wr(4'd15, 32'hFFFFFFFF, 4'hF);
    rd(4'd8, 32'h0);
    rd(4'd15, 32'h0);

    // Byte-enabled write, read latency and hold.
    wr(4'd0, 32'hDEADBEEF, 4'b0101);
    rd(4'd0, 32'h00AD00EF);
    @(negedge CLK);
    check_val("rdata_hold", {96'b0, AVL_READDATA}, {96'b0, 32'h00AD00EF});
    rw(4'd0, 32'h11223344, 4'hF, 32'h00AD00EF);
    rd(4'd0, 32'h11223344);

    // Load key and encrypted message.
    for (int i = 0; i < 4; i++) begin
      key_w = KEY[127 - 32*i -: 32];
      enc_w = ENC[127 - 32*i -: 32];
      wr(4'(i), key_w, 4'hF);
      wr(4'(4 + i), enc_w, 4'hF);
    end
    check_val("aes_key", AES_KEY, KEY);
    check_val("aes_msg_enc", AES_MSG_ENC, ENC);
    check_val("export", {96'b0, EXPORT_DATA}, {96'b0, 32'h00010E0F});
    wr(4'd12, 32'hCAFEF00D, 4'hF);
    rd(4'd12, 32'hCAFEF00D);

    // IDLE -> RUN; key/message frozen.
    check_val("start_idle", {127'b0, AES_START}, 128'h0);
    wr(4'd14, 32'h1, 4'hF);
    check_val("start_run", {127'b0, AES_START}, 128'h1);
    rd(4'd15, 32'h0);
    rd(4'd14, 32'h1);
    wr(4'd0, 32'hFFFFFFFF, 4'hF);
    wr(4'd4, 32'hFFFFFFFF, 4'hF);
    rd(4'd0, 32'h00010203);
    rd(4'd4, 32'h10203040);
    check_val("key_frozen", AES_KEY, KEY);

    // RUN -> DONE with capture.
    pulse_done(DEC1);
    check_val("start_done", {127'b0, AES_START}, 128'h0);
    rd_block(4'd8, DEC1);
    rd(4'd15, 32'h1);

    // Completion outside RUN is ignored.
    pulse_done(DEC2);
    rd(4'd8, 32'h01234567);
    rd(4'd15, 32'h1);

    // DONE -> RUN clears DONE.
    wr(4'd14, 32'h1, 4'hF);
    check_val("start_rerun", {127'b0, AES_START}, 128'h1);
    rd(4'd15, 32'h0);

    // Abort coincident with completion: abort wins, no capture.
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 4'd14;
    AVL_WRITEDATA = 32'h0; AVL_BYTE_EN = 4'b0001;
    AES_DONE = 1'b1; AES_MSG_DEC = DEC2;
    @(negedge CLK);
    bus_idle();
    AES_DONE = 1'b0;
    check_val("start_abort", {127'b0, AES_START}, 128'h0);
    rd(4'd15, 32'h0);
    rd_block(4'd8, DEC1);

    // START written without byte 0: bytes stored, FSM untouched.
    wr(4'd14, 32'hA5A5A5A1, 4'b1110);
    check_val("start_no_b0", {127'b0, AES_START}, 128'h0);
    rd(4'd14, 32'hA5A5A500);

    // Reset mid-RUN, with a coincident write and completion.
    wr(4'd14, 32'h1, 4'hF);
    check_val("start_run2", {127'b0, AES_START}, 128'h1);
    rd(4'd0, 32'h00010203);
    @(negedge CLK);
    RESET = 1'b1;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 4'd12;
    AVL_WRITEDATA = 32'hFFFFFFFF; AVL_BYTE_EN = 4'hF;
    AES_DONE = 1'b1; AES_MSG_DEC = DEC2;
    @(negedge CLK);
    RESET = 1'b0;
    bus_idle();
    AES_DONE = 1'b0;
    check_val("rst_run_start", {127'b0, AES_START}, 128'h0);
    check_val("rst_run_rdata", {96'b0, AVL_READDATA}, 128'h0);
    check_val("rst_run_export", {96'b0, EXPORT_DATA}, 128'h0);
    check_val("rst_run_key", AES_KEY, 128'h0);
    check_val("rst_run_enc", AES_MSG_ENC, 128'h0);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), 32'h0);
    end

    @(negedge CLK);
    check_val("sb_drain", 128'(sb_q.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_aes_regbank.md
AVALON_AES_REGBANK -- requirements
Module: avalon_aes_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 32: Avalon data width in bits; multiple of 8.
REQ-002 SHALL have parameter BLOCK_W, default 128: AES block/key width in bits; multiple of DATA_W; WORDS = BLOCK_W/DATA_W.
REQ-003 SHALL have parameter NUM_REGS, default 16: register count; power of two, >= 3*WORDS+2; ADDR_W = log2(NUM_REGS).
REQ-004 SHALL have port CLK  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports AVL_READ, AVL_WRITE, AVL_CS  in  1 each  Avalon-MM slave read, write, chip select.
REQ-007 SHALL have port AVL_BYTE_EN  in  DATA_W/8  per-byte write enable.
REQ-008 SHALL have port AVL_ADDR  in  ADDR_W  word address.
REQ-009 SHALL have ports AVL_WRITEDATA  in  DATA_W, and AVL_READDATA  out  DATA_W.
REQ-010 SHALL have port EXPORT_DATA  out  DATA_W  {key word 0 upper half, key word WORDS-1 lower half}, combinational from registers.
REQ-011 SHALL have ports AES_KEY, AES_MSG_ENC  out  BLOCK_W  concatenated key/encrypted-message registers, word 0 most significant.
REQ-012 SHALL have ports AES_MSG_DEC  in  BLOCK_W  core result; AES_DONE  in  1  core completion; AES_START  out  1  core run request.

Function
REQ-013 Register map SHALL be: key 0..WORDS-1; encrypted message WORDS..2W-1; decrypted message 2W..3W-1; scratch 3W..NUM_REGS-3; START at NUM_REGS-2; DONE at NUM_REGS-1.
REQ-014 A write (AVL_CS & AVL_WRITE) SHALL update, on the same clock edge, only bytes whose AVL_BYTE_EN bit is 1; other bytes hold; no staging register.
REQ-015 Writes to decrypted-message and DONE addresses SHALL be ignored (read-only).
REQ-016 Writes to key and encrypted-message addresses SHALL be ignored while state is RUN.
REQ-017 Reads (AVL_CS & AVL_READ) SHALL return the addressed register on AVL_READDATA with fixed latency 1; AVL_READDATA holds its last value otherwise.
REQ-018 Read of an address written in the same cycle SHALL return the pre-write value.
REQ-019 FSM states SHALL be IDLE, RUN, DONE.
REQ-020 IDLE->RUN when START bit 0 is written 1 (byte 0 enabled); DONE register cleared to 0 on that edge.
REQ-021 RUN->DONE when AES_DONE=1: AES_MSG_DEC captured into decrypted registers, DONE register set to 1, same edge.
REQ-022 RUN->IDLE (abort) when START bit 0 is written 0; abort wins over a simultaneous AES_DONE; no capture, DONE stays 0.
REQ-023 DONE->IDLE when START bit 0 written 0 (DONE register cleared); DONE->RUN when START bit 0 written 1 (DONE register cleared).
REQ-024 AES_START SHALL be 1 exactly in state RUN (registered, no combinational path from bus).
REQ-025 AES_DONE outside RUN SHALL be ignored.
REQ-026 START register SHALL store full written bytes; only bit 0 is interpreted.

Reset
REQ-027 On RESET all registers, AVL_READDATA SHALL become 0, state IDLE, AES_START 0, on the next edge, including mid-RUN.
REQ-028 RESET SHALL take priority over any simultaneous bus write or AES_DONE.

Structure
REQ-029 Shared package aes_regbank_pkg SHALL hold the state enum and address-offset functions/constants derived from WORDS and NUM_REGS.
REQ-030 One sub-module, byte_merge (per-byte enable mux of old/new word), SHALL be instantiated per write path.

Verification
REQ-031 Write 32'hDEADBEEF to addr 0 with BYTE_EN=4'b0101 after reset -> reg0 = 32'h00AD00EF; read one cycle later returns it.
REQ-032 Write key 0..3 = 32'h00010203.., write START=1 -> AES_START=1 next cycle; write addr 0 in RUN -> reg0 unchanged.
REQ-033 In RUN pulse AES_DONE with AES_MSG_DEC=128'h0123..EF -> regs 8..11 match, DONE reads 1, AES_START=0.
REQ-034 Same cycle AES_DONE=1 and START written 0 -> IDLE, DONE reads 0, regs 8..11 unchanged.
REQ-035 Write 32'hFFFFFFFF to addrs 8 and 15 -> both read 0.
REQ-036 RESET asserted in RUN -> next cycle AES_START=0, all reads 0, EXPORT_DATA=0.
